// File: rtl/pool_window_gen_pkg.sv
// Shared constants and helpers for the 2x2 pooling window generator.
package pool_window_gen_pkg;

    localparam int unsigned DEF_W_BW = 8;
    localparam int unsigned DEF_CO   = 1;
    localparam int unsigned DEF_CI   = 4;

    // Element order inside one lane's packed window.
    typedef enum logic [1:0] {
        ElemTl = 2'd0,
        ElemTr = 2'd1,
        ElemBl = 2'd2,
        ElemBr = 2'd3
    } win_elem_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_window_gen_pair_buf.sv
// One row of {TR, TL} pixel pairs: synchronous write, combinational read, no reset.
module pool_pair_buf
    import pool_window_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 14,
    parameter int unsigned DW    = 64,
    parameter int unsigned AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool_window_gen.sv
// Turns a raster pixel stream into stride-2 2x2 windows packed per lane for the max-pool stage.
module pool_window_gen
    import pool_window_gen_pkg::*;
#(
    parameter int unsigned CH   = DEF_CO * DEF_CI,
    parameter int unsigned W_BW = DEF_W_BW,
    parameter int unsigned IW   = 28,
    parameter int unsigned IH   = 28
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_sof,
    input  logic                   i_valid,
    input  logic [CH*W_BW-1:0]     i_pix,
    output logic                   o_valid,
    output logic [CH*4*W_BW-1:0]   o_win,
    output logic                   o_eof
);

    localparam int unsigned PW    = CH * W_BW;
    localparam int unsigned PAIRS = IW / 2;
    localparam int unsigned CW    = cnt_w(IW);
    localparam int unsigned RW    = cnt_w(IH);
    localparam int unsigned AW    = cnt_w(PAIRS);

    localparam logic [CW-1:0] COL_LAST = CW'(IW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IH - 1);
    localparam logic [CW-1:0] COL_EOF  = CW'(2 * PAIRS - 1);
    localparam logic [RW-1:0] ROW_EOF  = RW'(2 * (IH / 2) - 1);
    localparam logic [CW-1:0] PAIRS_C  = CW'(PAIRS);

    logic [CW-1:0]   col_q, col_d, col;
    logic [RW-1:0]   row_q, row_d, row;
    logic [PW-1:0]   tl_q, bl_q;
    logic            in_pair, odd_row, odd_col, buf_we, emit;
    logic [AW-1:0]   pair_addr;
    logic [2*PW-1:0] pair_rd;
    logic [4*PW-1:0] win_d;

    always_comb begin
        // i_sof forces this pixel to (0,0) and drops any partially built window.
        col       = i_sof ? '0 : col_q;
        row       = i_sof ? '0 : row_q;
        in_pair   = (col >> 1) < PAIRS_C;
        odd_row   = row[0];
        odd_col   = col[0];
        pair_addr = AW'(col >> 1);
        buf_we    = i_valid && !odd_row && odd_col;
        emit      = i_valid && odd_row && odd_col;

        col_d = col_q;
        row_d = row_q;
        if (i_valid) begin
            if (col == COL_LAST) begin
                col_d = '0;
                row_d = (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col_d = col + CW'(1);
                row_d = row;
            end
        end else if (i_sof) begin
            col_d = '0;
            row_d = '0;
        end
    end

    always_comb begin
        win_d = '0;
        for (int c = 0; c < int'(CH); c++) begin
            win_d[(c*4 + int'(ElemTl))*W_BW +: W_BW] = pair_rd[c*W_BW +: W_BW];
            win_d[(c*4 + int'(ElemTr))*W_BW +: W_BW] = pair_rd[PW + c*W_BW +: W_BW];
            win_d[(c*4 + int'(ElemBl))*W_BW +: W_BW] = bl_q[c*W_BW +: W_BW];
            win_d[(c*4 + int'(ElemBr))*W_BW +: W_BW] = i_pix[c*W_BW +: W_BW];
        end
    end

    pool_pair_buf #(
        .DEPTH (PAIRS),
        .DW    (2 * PW),
        .AW    (AW)
    ) u_pair_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (pair_addr),
        .wdata ({i_pix, tl_q}),
        .raddr (pair_addr),
        .rdata (pair_rd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q   <= '0;
            row_q   <= '0;
            tl_q    <= '0;
            bl_q    <= '0;
            o_valid <= 1'b0;
            o_eof   <= 1'b0;
            o_win   <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            o_valid <= emit;
            o_eof   <= emit && (col == COL_EOF) && (row == ROW_EOF);
            if (emit) begin
                o_win <= win_d;
            end
            if (i_valid && !odd_row && !odd_col && in_pair) begin
                tl_q <= i_pix;
            end
            if (i_valid && odd_row && !odd_col && in_pair) begin
                bl_q <= i_pix;
            end
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench: 4x4 CH=1, 5x5 CH=1 and 4x4 CH=2 instances of the window generator.
module tb_pool_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        a_sof, a_valid, a_ov, a_eof;
    logic [7:0]  a_pix;
    logic [31:0] a_win;
    logic        b_sof, b_valid, b_ov, b_eof;
    logic [7:0]  b_pix;
    logic [31:0] b_win;
    logic        c_sof, c_valid, c_ov, c_eof;
    logic [15:0] c_pix;
    logic [63:0] c_win;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp4 [4] = '{32'h05040100, 32'h07060302, 32'h0D0C0908, 32'h0F0E0B0A};
    int          br4  [5] = '{5, 7, 13, 15, -1};
    logic [31:0] exp5 [4] = '{32'h06050100, 32'h08070302, 32'h100F0B0A, 32'h12110D0C};
    int          br5  [5] = '{6, 8, 16, 18, -1};

    pool_window_gen #(.CH(1), .W_BW(8), .IW(4), .IH(4)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .i_sof(a_sof), .i_valid(a_valid), .i_pix(a_pix),
        .o_valid(a_ov), .o_win(a_win), .o_eof(a_eof)
    );

    pool_window_gen #(.CH(1), .W_BW(8), .IW(5), .IH(5)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .i_sof(b_sof), .i_valid(b_valid), .i_pix(b_pix),
        .o_valid(b_ov), .o_win(b_win), .o_eof(b_eof)
    );

    pool_window_gen #(.CH(2), .W_BW(8), .IW(4), .IH(4)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .i_sof(c_sof), .i_valid(c_valid), .i_pix(c_pix),
        .o_valid(c_ov), .o_win(c_win), .o_eof(c_eof)
    );

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_a(input logic [7:0] p, input logic sof);
        a_pix = p; a_sof = sof; a_valid = 1'b1;
        idle();
        a_valid = 1'b0; a_sof = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_sof = 0; a_valid = 0; a_pix = '0;
        b_sof = 0; b_valid = 0; b_pix = '0;
        c_sof = 0; c_valid = 0; c_pix = '0;
        idle();
        idle();
        checks++;
        if ({a_ov, a_eof, a_win} !== 34'd0) begin
            errors++; $display("FAIL reset_a: got %h want 0", {a_ov, a_eof, a_win});
        end
        checks++;
        if ({b_ov, b_eof, b_win, c_ov, c_eof, c_win} !== 100'd0) begin
            errors++; $display("FAIL reset_bc: got %h want 0", {b_ov, b_eof, b_win, c_ov, c_eof, c_win});
        end
        reset_n = 1'b1;
        idle();
    endtask

    // Feeds one 4x4 frame into DUT a with `gap` idle cycles after every pixel.
    task automatic test_frame_a(input logic [7:0] base, input int gap, input string name);
        int          w = 0;
        logic [31:0] off = {base, base, base, base};
        logic        exp_v;
        for (int p = 0; p < 16; p++) begin
            feed_a(base + 8'(p), p == 0);
            exp_v = (p == br4[w]);
            checks++;
            if (a_ov !== exp_v) begin
                errors++; $display("FAIL %s valid p=%0d: got %b want %b", name, p, a_ov, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (a_win !== exp4[w] + off) begin
                    errors++; $display("FAIL %s win%0d: got %h want %h", name, w, a_win, exp4[w] + off);
                end
                checks++;
                if (a_eof !== (w == 3)) begin
                    errors++; $display("FAIL %s eof%0d: got %b want %b", name, w, a_eof, w == 3);
                end
                w++;
            end else begin
                checks++;
                if (a_eof !== 1'b0) begin
                    errors++; $display("FAIL %s eof p=%0d: got %b want 0", name, p, a_eof);
                end
            end
            for (int g = 0; g < gap; g++) begin
                idle();
                checks++;
                if (a_ov !== 1'b0) begin
                    errors++; $display("FAIL %s gap valid p=%0d: got %b want 0", name, p, a_ov);
                end
                if (w > 0) begin
                    checks++;
                    if (a_win !== exp4[w-1] + off) begin
                        errors++; $display("FAIL %s hold p=%0d: got %h want %h", name, p, a_win, exp4[w-1] + off);
                    end
                end
            end
        end
    endtask

    task automatic test_odd_dims();
        int w = 0;
        for (int p = 0; p < 25; p++) begin
            b_pix = 8'(p); b_sof = (p == 0); b_valid = 1'b1;
            idle();
            b_valid = 1'b0; b_sof = 1'b0;
            checks++;
            if (b_ov !== (p == br5[w])) begin
                errors++; $display("FAIL odd_valid p=%0d: got %b want %b", p, b_ov, p == br5[w]);
            end
            if (p == br5[w]) begin
                checks++;
                if ({b_win, b_eof} !== {exp5[w], w == 3}) begin
                    errors++; $display("FAIL odd_win%0d: got %h/%b want %h/%b", w, b_win, b_eof, exp5[w], w == 3);
                end
                w++;
            end
        end
    endtask

    task automatic test_two_lanes();
        int          w = 0;
        logic [63:0] want;
        for (int p = 0; p < 16; p++) begin
            c_pix = {8'(p) + 8'h80, 8'(p)}; c_sof = (p == 0); c_valid = 1'b1;
            idle();
            c_valid = 1'b0; c_sof = 1'b0;
            checks++;
            if (c_ov !== (p == br4[w])) begin
                errors++; $display("FAIL lanes_valid p=%0d: got %b want %b", p, c_ov, p == br4[w]);
            end
            if (p == br4[w]) begin
                want = {exp4[w] + 32'h80808080, exp4[w]};
                checks++;
                if ({c_win, c_eof} !== {want, w == 3}) begin
                    errors++; $display("FAIL lanes_win%0d: got %h/%b want %h/%b", w, c_win, c_eof, want, w == 3);
                end
                w++;
            end
        end
    endtask

    task automatic test_sof_abort();
        for (int p = 0; p < 7; p++) feed_a(8'(p), p == 0);
        a_sof = 1'b1;
        idle();
        a_sof = 1'b0;
        checks++;
        if (a_ov !== 1'b0) begin
            errors++; $display("FAIL sof_alone valid: got %b want 0", a_ov);
        end
        test_frame_a(8'h40, 0, "sof_alone_frame");
        for (int p = 0; p < 5; p++) begin
            feed_a(8'(p), p == 0);
            checks++;
            if (a_ov !== 1'b0) begin
                errors++; $display("FAIL abort valid p=%0d: got %b want 0", p, a_ov);
            end
        end
        test_frame_a(8'h40, 0, "abort_frame");
    endtask

    task automatic test_mid_reset();
        for (int p = 0; p < 6; p++) feed_a(8'(p), p == 0);
        checks++;
        if (a_win !== exp4[0]) begin
            errors++; $display("FAIL pre_reset win: got %h want %h", a_win, exp4[0]);
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if ({a_ov, a_eof, a_win} !== 34'd0) begin
            errors++; $display("FAIL mid_reset: got %h want 0", {a_ov, a_eof, a_win});
        end
        idle();
        idle();
        reset_n = 1'b1;
        // Restart without i_sof: counters must already be at (0,0).
        for (int p = 0; p < 6; p++) feed_a(8'(p), 1'b0);
        checks++;
        if ({a_ov, a_win} !== {1'b1, exp4[0]}) begin
            errors++; $display("FAIL post_reset win: got %b/%h want 1/%h", a_ov, a_win, exp4[0]);
        end
        for (int p = 6; p < 16; p++) feed_a(8'(p), 1'b0);
        test_frame_a(8'h00, 0, "post_reset_frame");
    endtask

    initial begin
        test_reset();
        test_frame_a(8'h00, 0, "b2b");
        test_frame_a(8'h00, 3, "gaps");
        test_frame_a(8'h00, 0, "two_frames_1");
        test_frame_a(8'h20, 0, "two_frames_2");
        test_odd_dims();
        test_sof_abort();
        test_mid_reset();
        test_two_lanes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
